inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Sequences the instruction-side fetch between the PC register, the I-cache (SRAM-like req/addr_ok/data_ok interface) and the instruction FIFO.
- Issues one dual-word fetch at a time from the current PC.
- Drops responses made stale by an exception or taken-branch redirect.
- Produces the per-lane data_ok strobes that advance the PC register by 0, 4 or 8.

Parameters:
- ADDR_W, 32, instruction address width.
- FIFO_FREE_MIN, 2, minimum free FIFO slots required before a new request is issued.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- pc_curr  input  ADDR_W  current fetch PC from the PC register
- redirect  input  1  is_except OR (branch_en AND branch_taken) this cycle
- fifo_free  input  4  free FIFO slots, 0..8
- inst_req  output  1  I-cache request valid
- inst_addr  output  ADDR_W  I-cache request address, 8-byte-aligned pc_curr
- inst_addr_ok  input  1  I-cache accepted the address
- inst_data_ok  input  1  I-cache response valid
- inst_rdata0  input  32  word at the aligned address
- inst_rdata1  input  32  word at the aligned address + 4
- inst_data_ok1  output  1  lane-0 instruction delivered (to the PC register)
- inst_data_ok2  output  1  lane-1 instruction also delivered (to the PC register)
- fifo_push0  output  1  push lane 0 into the FIFO
- fifo_push1  output  1  push lane 1 into the FIFO
- fifo_inst0  output  32  lane-0 instruction
- fifo_inst1  output  32  lane-1 instruction
- fifo_pc0  output  ADDR_W  lane-0 PC
- fifo_pc1  output  ADDR_W  lane-1 PC

Behaviour:
- States: IDLE, REQ, WAIT, DISCARD. Reset to IDLE; all outputs 0 in the reset cycle and until the first response.
- inst_req = (state==REQ) AND NOT redirect. inst_addr = {pc_curr[ADDR_W-1:3],3'b000}.
- req_pc register captures pc_curr on an accepted request (inst_req AND inst_addr_ok); reset 0.
- IDLE -> REQ when fifo_free >= FIFO_FREE_MIN and NOT redirect; otherwise stay.
- REQ:
  - redirect asserted: inst_req is withdrawn and state -> IDLE. Withdrawal before addr_ok is a legal I-cache protocol case.
  - inst_addr_ok without redirect: -> WAIT.
  - otherwise: hold REQ and keep the address stable.
- WAIT:
  - inst_data_ok without redirect: deliver; -> REQ if fifo_free >= FIFO_FREE_MIN + 2, else IDLE.
  - inst_data_ok together with redirect: data dropped, nothing delivered; -> IDLE.
  - redirect without inst_data_ok: -> DISCARD.
- DISCARD: inst_data_ok -> IDLE, data dropped. Further redirects are ignored here. No new request while in DISCARD.
- Deliver (combinational, same cycle as inst_data_ok):
  - fifo_push0 = inst_data_ok1 = 1.
  - fifo_inst0 = req_pc[2] ? rdata1 : rdata0; fifo_pc0 = req_pc.
  - fifo_push1 = inst_data_ok2 = NOT req_pc[2]; fifo_inst1 = rdata1; fifo_pc1 = req_pc + 4.
  - An odd-word PC therefore yields a single instruction.
- Simultaneous events:
  - redirect has priority over addr_ok and data_ok in every state.
  - The PC register's own redirect handling overrides the +4/+8, so zero delivery on a redirect cycle is required.
- At most one outstanding request; the I-cache never receives a second request before data_ok or discard completes.
- rst mid-transaction: state -> IDLE; any later stale data_ok is ignored (IDLE ignores data_ok).
- PC arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - adds 32-bit output perf_discard_cnt, counting responses dropped in DISCARD or in WAIT-with-redirect;
  - adds 32-bit output perf_stall_cnt, counting cycles in IDLE with fifo_free < FIFO_FREE_MIN;
  - both counters reset to 0, saturate at 0xFFFFFFFF, and do not change control behaviour.
- When undefined: the ports and counters are absent.

Decomposition:
- Shared package cpu_defs_pkg:
  - typedef enum logic[1:0] fetch_state_t {IDLE, REQ, WAIT, DISCARD};
  - constant RESET_PC = 32'hbfc00000;
  - typedef struct fetch_entry_t {inst, pc}.
- Single module; no sub-module. The optional counters are an inline generate-style block, not a separate module.

Test Plan:
- Aligned fetch: pc_curr=0xbfc00000, fifo_free=8, addr_ok next cycle, data_ok two cycles later with rdata0=0x11, rdata1=0x22 -> push0/push1 both 1, pcs 0xbfc00000 and 0xbfc00004, inst_data_ok1 and inst_data_ok2 both 1.
- Odd PC: pc_curr=0xbfc00004 -> inst_addr=0xbfc00000; response delivers only lane 0 = rdata1 with pc 0xbfc00004; inst_data_ok2=0.
- Redirect in WAIT: redirect pulse one cycle before data_ok -> state DISCARD, no push, inst_req=0 until after data_ok; next request uses the new pc_curr=0x80000180.
- Redirect in REQ without addr_ok -> inst_req drops the same cycle, state IDLE, no data_ok expected, no push.
- FIFO backpressure: fifo_free=1 -> inst_req stays 0 indefinitely; raising it to 2 -> REQ on the next cycle.
- rst asserted in WAIT, then data_ok arrives -> no push, outputs 0, state IDLE; with FETCH_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, reset vector and FIFO entry payload.
package cpu_defs_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} fetch_state_t;

   localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer between PC register, I-cache and instruction FIFO.
// Optional FETCH_PERF_CNT_EN adds saturating discard/stall performance counters.
module inst_fetch_ctrl
   import cpu_defs_pkg::*;
#(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned FIFO_FREE_MIN = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_curr,
   input  logic              redirect,
   input  logic [3:0]        fifo_free,
   output logic              inst_req,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [31:0]       inst_rdata0,
   input  logic [31:0]       inst_rdata1,
   output logic              inst_data_ok1,
   output logic              inst_data_ok2,
   output logic              fifo_push0,
   output logic              fifo_push1,
   output logic [31:0]       fifo_inst0,
   output logic [31:0]       fifo_inst1,
   output logic [ADDR_W-1:0] fifo_pc0,
   output logic [ADDR_W-1:0] fifo_pc1
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_discard_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);

   localparam logic [3:0] FREE_REQ  = 4'(FIFO_FREE_MIN);
   localparam logic [3:0] FREE_NEXT = 4'(FIFO_FREE_MIN + 2);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              deliver_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
      end
   end

   // Redirect wins over addr_ok/data_ok in every state.
   always_comb begin
      state_d   = state_q;
      req_pc_d  = req_pc_q;
      inst_req  = 1'b0;
      deliver_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fifo_free >= FREE_REQ && !redirect) state_d = REQ;
         end
         REQ: begin
            inst_req = !redirect;
            if (redirect) begin
               state_d = IDLE;
            end else if (inst_addr_ok) begin
               state_d  = WAIT;
               req_pc_d = pc_curr;
            end
         end
         WAIT: begin
            if (inst_data_ok) begin
               state_d = IDLE;
               if (!redirect) begin
                  deliver_c = 1'b1;
                  // A dual-word push consumes two slots before the next request.
                  if (fifo_free >= FREE_NEXT) state_d = REQ;
               end
            end else if (redirect) begin
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (inst_data_ok) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         inst_req  = 1'b0;
         deliver_c = 1'b0;
      end
   end

   assign inst_addr     = rst ? '0 : {pc_curr[ADDR_W-1:3], 3'b000};
   assign inst_data_ok1 = deliver_c;
   assign fifo_push0    = deliver_c;
   // An odd-word PC only has its own word left in the fetched pair.
   assign inst_data_ok2 = deliver_c & ~req_pc_q[2];
   assign fifo_push1    = deliver_c & ~req_pc_q[2];
   assign fifo_inst0    = deliver_c ? (req_pc_q[2] ? inst_rdata1 : inst_rdata0) : '0;
   assign fifo_inst1    = deliver_c ? inst_rdata1 : '0;
   assign fifo_pc0      = deliver_c ? req_pc_q : '0;
   assign fifo_pc1      = deliver_c ? req_pc_q + ADDR_W'(4) : '0;

`ifdef FETCH_PERF_CNT_EN
   logic drop_c, stall_c;

   assign drop_c  = inst_data_ok &&
                    ((state_q == DISCARD) || (state_q == WAIT && redirect));
   assign stall_c = (state_q == IDLE) && (fifo_free < FREE_REQ);

   // Saturating observation-only counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_discard_cnt <= '0;
         perf_stall_cnt   <= '0;
      end else begin
         if (drop_c && perf_discard_cnt != '1)
            perf_discard_cnt <= perf_discard_cnt + 32'd1;
         if (stall_c && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`else
   // Counters compiled out; the control path is identical either way.
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios plus a randomized
// run against a transaction-level fetch model (FETCH_PERF_CNT_EN optional).
module tb_inst_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] pc_curr;
   logic        redirect;
   logic [3:0]  fifo_free;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata0;
   logic [31:0] inst_rdata1;
   logic        inst_data_ok1;
   logic        inst_data_ok2;
   logic        fifo_push0;
   logic        fifo_push1;
   logic [31:0] fifo_inst0;
   logic [31:0] fifo_inst1;
   logic [31:0] fifo_pc0;
   logic [31:0] fifo_pc1;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_discard_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   inst_fetch_ctrl #(.ADDR_W(32), .FIFO_FREE_MIN(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_curr       (pc_curr),
      .redirect      (redirect),
      .fifo_free     (fifo_free),
      .inst_req      (inst_req),
      .inst_addr     (inst_addr),
      .inst_addr_ok  (inst_addr_ok),
      .inst_data_ok  (inst_data_ok),
      .inst_rdata0   (inst_rdata0),
      .inst_rdata1   (inst_rdata1),
      .inst_data_ok1 (inst_data_ok1),
      .inst_data_ok2 (inst_data_ok2),
      .fifo_push0    (fifo_push0),
      .fifo_push1    (fifo_push1),
      .fifo_inst0    (fifo_inst0),
      .fifo_inst1    (fifo_inst1),
      .fifo_pc0      (fifo_pc0),
      .fifo_pc1      (fifo_pc1)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_discard_cnt (perf_discard_cnt),
      .perf_stall_cnt   (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic r, input logic red, input logic [3:0] ff,
                        input logic aok, input logic dok, input logic [31:0] pc,
                        input logic [31:0] d0, input logic [31:0] d1);
      @(negedge clk);
      rst = r; redirect = red; fifo_free = ff; inst_addr_ok = aok;
      inst_data_ok = dok; pc_curr = pc; inst_rdata0 = d0; inst_rdata1 = d1;
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 4'd8, 1'b1, 1'b1, 32'hbfc00000, 32'h1, 32'h2);
      n_chk++; if ({inst_req, fifo_push0, fifo_push1, inst_data_ok1, inst_data_ok2} !== 5'b0)
         $display("FAIL reset_ctrl: got %b exp 00000", {inst_req, fifo_push0, fifo_push1, inst_data_ok1, inst_data_ok2});
      else n_pass++;
      n_chk++; if ({fifo_inst0, fifo_inst1, fifo_pc0, fifo_pc1, inst_addr} !== 160'b0)
         $display("FAIL reset_data: got %h exp 0", {fifo_inst0, fifo_inst1, fifo_pc0, fifo_pc1, inst_addr});
      else n_pass++;
      drive(1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic test_aligned();
      do_reset();
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      n_chk++; if (inst_req !== 1'b0) $display("FAIL aligned_idle_req: got %b exp 0", inst_req); else n_pass++;
      drive(1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      n_chk++; if (inst_req !== 1'b1) $display("FAIL aligned_req: got %b exp 1", inst_req); else n_pass++;
      n_chk++; if (inst_addr !== 32'hbfc00000) $display("FAIL aligned_addr: got %h exp bfc00000", inst_addr); else n_pass++;
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      n_chk++; if ({inst_req, fifo_push0} !== 2'b00) $display("FAIL aligned_wait: got %b exp 00", {inst_req, fifo_push0}); else n_pass++;
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 32'hbfc00000, 32'h11, 32'h22);
      n_chk++; if ({fifo_push0, fifo_push1, inst_data_ok1, inst_data_ok2} !== 4'b1111)
         $display("FAIL aligned_push: got %b exp 1111", {fifo_push0, fifo_push1, inst_data_ok1, inst_data_ok2});
      else n_pass++;
      n_chk++; if ({fifo_inst0, fifo_inst1} !== {32'h11, 32'h22})
         $display("FAIL aligned_inst: got %h %h exp 11 22", fifo_inst0, fifo_inst1);
      else n_pass++;
      n_chk++; if ({fifo_pc0, fifo_pc1} !== {32'hbfc00000, 32'hbfc00004})
         $display("FAIL aligned_pc: got %h %h exp bfc00000 bfc00004", fifo_pc0, fifo_pc1);
      else n_pass++;
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 32'hbfc00008, 32'h0, 32'h0);
      n_chk++; if ({inst_req, inst_addr} !== {1'b1, 32'hbfc00008})
         $display("FAIL aligned_next_req: got %b %h exp 1 bfc00008", inst_req, inst_addr);
      else n_pass++;
   endtask

   task automatic test_odd_pc();
      do_reset();
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 32'hbfc00004, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 32'hbfc00004, 32'h0, 32'h0);
      n_chk++; if ({inst_req, inst_addr} !== {1'b1, 32'hbfc00000})
         $display("FAIL odd_addr: got %b %h exp 1 bfc00000", inst_req, inst_addr);
      else n_pass++;
      drive(1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 32'hbfc00004, 32'haa, 32'hbb);
      n_chk++; if ({fifo_push0, fifo_push1, inst_data_ok1, inst_data_ok2} !== 4'b1010)
         $display("FAIL odd_push: got %b exp 1010", {fifo_push0, fifo_push1, inst_data_ok1, inst_data_ok2});
      else n_pass++;
      n_chk++; if ({fifo_inst0, fifo_pc0} !== {32'hbb, 32'hbfc00004})
         $display("FAIL odd_lane0: got %h %h exp bb bfc00004", fifo_inst0, fifo_pc0);
      else n_pass++;
      // fifo_free=2 is below the post-delivery threshold of 4.
      drive(1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 32'hbfc00008, 32'h0, 32'h0);
      n_chk++; if (inst_req !== 1'b0) $display("FAIL odd_low_free_req: got %b exp 0", inst_req); else n_pass++;
   endtask

   task automatic test_redirect_wait();
      do_reset();
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 32'h80000180, 32'h0, 32'h0);
      n_chk++; if ({inst_req, fifo_push0} !== 2'b00) $display("FAIL rw_redirect: got %b exp 00", {inst_req, fifo_push0}); else n_pass++;
      drive(1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 32'h80000180, 32'h0, 32'h0);
      n_chk++; if (inst_req !== 1'b0) $display("FAIL rw_discard_req: got %b exp 0", inst_req); else n_pass++;
      drive(1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 32'h80000180, 32'h0, 32'h0);
      n_chk++; if (inst_req !== 1'b0) $display("FAIL rw_discard_redir: got %b exp 0", inst_req); else n_pass++;
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 32'h80000180, 32'h55, 32'h66);
      n_chk++; if ({inst_req, fifo_push0, fifo_push1, inst_data_ok1} !== 4'b0000)
         $display("FAIL rw_drop: got %b exp 0000", {inst_req, fifo_push0, fifo_push1, inst_data_ok1});
      else n_pass++;
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 32'h80000180, 32'h0, 32'h0);
      n_chk++; if (inst_req !== 1'b0) $display("FAIL rw_idle_req: got %b exp 0", inst_req); else n_pass++;
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 32'h80000180, 32'h0, 32'h0);
      n_chk++; if ({inst_req, inst_addr} !== {1'b1, 32'h80000180})
         $display("FAIL rw_new_req: got %b %h exp 1 80000180", inst_req, inst_addr);
      else n_pass++;
`ifdef FETCH_PERF_CNT_EN
      n_chk++; if (perf_discard_cnt !== 32'd1) $display("FAIL rw_perf_discard: got %0d exp 1", perf_discard_cnt); else n_pass++;
`endif
   endtask

   task automatic test_redirect_req();
      do_reset();
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      n_chk++; if (inst_req !== 1'b0) $display("FAIL rr_withdraw: got %b exp 0", inst_req); else n_pass++;
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 32'h80000000, 32'h77, 32'h88);
      n_chk++; if ({inst_req, fifo_push0, inst_data_ok1} !== 3'b000)
         $display("FAIL rr_idle: got %b exp 000", {inst_req, fifo_push0, inst_data_ok1});
      else n_pass++;
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 32'h80000000, 32'h0, 32'h0);
      n_chk++; if ({inst_req, inst_addr} !== {1'b1, 32'h80000000})
         $display("FAIL rr_rereq: got %b %h exp 1 80000000", inst_req, inst_addr);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
         n_chk++; if (inst_req !== 1'b0) $display("FAIL bp_stall_%0d: got %b exp 0", i, inst_req); else n_pass++;
      end
      drive(1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      n_chk++; if (inst_req !== 1'b0) $display("FAIL bp_raise: got %b exp 0", inst_req); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
      n_chk++; if (perf_stall_cnt !== 32'd10) $display("FAIL bp_perf_stall: got %0d exp 10", perf_stall_cnt); else n_pass++;
`endif
      drive(1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      n_chk++; if (inst_req !== 1'b1) $display("FAIL bp_req: got %b exp 1", inst_req); else n_pass++;
   endtask

   task automatic test_rst_mid();
      do_reset();
      drive(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      n_chk++; if ({inst_req, fifo_push0} !== 2'b00) $display("FAIL rm_rst: got %b exp 00", {inst_req, fifo_push0}); else n_pass++;
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 32'hbfc00000, 32'h99, 32'haa);
      n_chk++; if ({inst_req, fifo_push0, fifo_push1, inst_data_ok1, inst_data_ok2} !== 5'b0)
         $display("FAIL rm_stale_ctrl: got %b exp 00000", {inst_req, fifo_push0, fifo_push1, inst_data_ok1, inst_data_ok2});
      else n_pass++;
      n_chk++; if ({fifo_inst0, fifo_inst1, fifo_pc0, fifo_pc1} !== 128'b0)
         $display("FAIL rm_stale_data: got %h exp 0", {fifo_inst0, fifo_inst1, fifo_pc0, fifo_pc1});
      else n_pass++;
      drive(1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 32'hbfc00000, 32'h0, 32'h0);
      n_chk++; if (inst_req !== 1'b1) $display("FAIL rm_rereq: got %b exp 1", inst_req); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
      n_chk++; if ({perf_discard_cnt, perf_stall_cnt} !== 64'b0)
         $display("FAIL rm_perf: got %0d %0d exp 0 0", perf_discard_cnt, perf_stall_cnt);
      else n_pass++;
`endif
   endtask

   // Model tracks the fetch as a transaction: pending request, outstanding
   // response and whether that response has been made stale.
   task automatic test_random();
      logic        r, red, aok, dok, exp_req, exp_del, exp_del1;
      logic [3:0]  ff;
      logic [31:0] pc, d0, d1, opc;
      logic        pend, outst, stale, c_busy;
      int unsigned exp_disc, exp_stall;
      pend = 1'b0; outst = 1'b0; stale = 1'b0; c_busy = 1'b0; opc = '0;
      exp_disc = 0; exp_stall = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         r   = ($urandom_range(0, 99) == 0);
         red = ($urandom_range(0, 7) == 0);
         ff  = 4'($urandom_range(0, 8));
         aok = !c_busy && ($urandom_range(0, 1) == 1);
         dok = c_busy && ($urandom_range(0, 2) == 0);
         pc  = $urandom & 32'hffff_fffc;
         d0  = $urandom;
         d1  = $urandom;
         drive(r, red, ff, aok, dok, pc, d0, d1);
         exp_req  = !r && pend && !red;
         exp_del  = !r && outst && !stale && dok && !red;
         exp_del1 = exp_del && !opc[2];
         n_chk++; if (inst_req !== exp_req) $display("FAIL rnd_req[%0d]: got %b exp %b", i, inst_req, exp_req); else n_pass++;
         if (exp_req) begin
            n_chk++; if (inst_addr !== {pc[31:3], 3'b000})
               $display("FAIL rnd_addr[%0d]: got %h exp %h", i, inst_addr, {pc[31:3], 3'b000});
            else n_pass++;
         end
         n_chk++; if ({fifo_push0, fifo_push1, inst_data_ok1, inst_data_ok2} !== {exp_del, exp_del1, exp_del, exp_del1})
            $display("FAIL rnd_push[%0d]: got %b exp %b", i, {fifo_push0, fifo_push1, inst_data_ok1, inst_data_ok2},
                     {exp_del, exp_del1, exp_del, exp_del1});
         else n_pass++;
         n_chk++; if (fifo_inst0 !== (exp_del ? (opc[2] ? d1 : d0) : 32'h0))
            $display("FAIL rnd_inst0[%0d]: got %h exp %h", i, fifo_inst0, exp_del ? (opc[2] ? d1 : d0) : 32'h0);
         else n_pass++;
         n_chk++; if (fifo_inst1 !== (exp_del ? d1 : 32'h0))
            $display("FAIL rnd_inst1[%0d]: got %h exp %h", i, fifo_inst1, exp_del ? d1 : 32'h0);
         else n_pass++;
         n_chk++; if ({fifo_pc0, fifo_pc1} !== (exp_del ? {opc, opc + 32'd4} : 64'h0))
            $display("FAIL rnd_pc[%0d]: got %h %h exp %h", i, fifo_pc0, fifo_pc1, exp_del ? {opc, opc + 32'd4} : 64'h0);
         else n_pass++;
`ifdef FETCH_PERF_CNT_EN
         n_chk++; if ({perf_discard_cnt, perf_stall_cnt} !== {exp_disc, exp_stall})
            $display("FAIL rnd_perf[%0d]: got %0d %0d exp %0d %0d", i, perf_discard_cnt, perf_stall_cnt, exp_disc, exp_stall);
         else n_pass++;
`endif
         if (exp_req && aok) c_busy = 1'b1;
         if (dok) c_busy = 1'b0;
         if (r) begin
            pend = 1'b0; outst = 1'b0; stale = 1'b0; exp_disc = 0; exp_stall = 0;
         end else begin
            if (outst && dok && (stale || red)) exp_disc++;
            if (!pend && !outst && ff < 4'd2) exp_stall++;
            if (pend) begin
               if (red) pend = 1'b0;
               else if (aok) begin
                  pend = 1'b0; outst = 1'b1; stale = 1'b0; opc = pc;
               end
            end else if (outst) begin
               if (dok) begin
                  outst = 1'b0;
                  if (!stale && !red && ff >= 4'd4) pend = 1'b1;
               end else if (red) stale = 1'b1;
            end else if (ff >= 4'd2 && !red) pend = 1'b1;
         end
      end
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; fifo_free = 4'd0; inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0; pc_curr = '0; inst_rdata0 = '0; inst_rdata1 = '0;
      test_reset();
      test_aligned();
      test_odd_pc();
      test_redirect_wait();
      test_redirect_req();
      test_backpressure();
      test_rst_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
